apb_master: RTL and testbench

- APB requester (initiator) that drives the PSEL/PENABLE two-phase protocol toward the team's APB slaves.
- Accepts single read/write commands on a valid/ready request port.
- Sequences IDLE -> SETUP -> ACCESS, honours PREADY wait states and guards against hung slaves with a timeout.
- Returns the completion on a one-cycle response strobe.

---
 rtl/apb_pkg.sv | 24 ++
 rtl/apb_wait_timer.sv | 46 ++++
 rtl/apb_master.sv | 141 ++++++++++++++
 tb/tb_apb_master.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions.
// Holds the requester FSM state encoding, the slave-side operation encoding,
// and the default data width, address width and wait-state timeout.
package apb_pkg;

  localparam int K_DEF       = 8;
  localparam int A_DEF       = 4;
  localparam int TIMEOUT_DEF = 16;

  // Requester FSM. 2'b11 is unused and falls back to IDLE.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_t;

  // Slave-side decode of the current bus cycle.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10
  } apb_op_t;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts consecutive wait-state cycles of one APB access.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   clear      : forces the count back to zero (any cycle outside ACCESS)
//   enable     : ACCESS cycle with the slave not ready
//   expired    : high in the wait cycle that completes TIMEOUT low cycles
module apb_wait_timer
  import apb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The count holds the number of earlier low cycles, so reaching LAST while
  // still low means this is the TIMEOUT-th consecutive low cycle.
  assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/apb_master.sv
// APB requester: takes single read/write commands on a valid/ready port,
// runs them as SETUP + ACCESS on the APB bus, honours PREADY wait states,
// aborts after TIMEOUT consecutive wait cycles, and reports completion on a
// one-cycle response strobe.
// Ports:
//   PCLK, Presetn                    : clock, asynchronous active-low reset
//   req_valid/req_ready              : command handshake (ready only in IDLE)
//   req_write/req_addr/req_wdata     : command contents
//   rsp_valid/rsp_rdata/rsp_err      : completion strobe, read data, timeout flag
//   Psel/Penable/Pwrite/Paddress/Pwdata : APB request signals (registered)
//   Pready/PRdata                    : APB slave response, used only in ACCESS
module apb_master
  import apb_pkg::*;
#(
  parameter int K       = K_DEF,
  parameter int A       = A_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic         PCLK,
  input  logic         Presetn,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [A-1:0] req_addr,
  input  logic [K-1:0] req_wdata,
  output logic         rsp_valid,
  output logic [K-1:0] rsp_rdata,
  output logic         rsp_err,
  output logic         Psel,
  output logic         Penable,
  output logic         Pwrite,
  output logic [A-1:0] Paddress,
  output logic [K-1:0] Pwdata,
  input  logic         Pready,
  input  logic [K-1:0] PRdata
);

  apb_state_t   state_q, state_d;
  logic         psel_q, psel_d;
  logic         penable_q, penable_d;
  logic         pwrite_q, pwrite_d;
  logic [A-1:0] paddr_q, paddr_d;
  logic [K-1:0] pwdata_q, pwdata_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic         rsp_err_q, rsp_err_d;
  logic [K-1:0] rsp_rdata_q, rsp_rdata_d;
  logic         wait_expired;

  apb_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk    (PCLK),
    .rst_n  (Presetn),
    .clear  (state_q != ACCESS),
    .enable ((state_q == ACCESS) && !Pready),
    .expired(wait_expired)
  );

  // Psel/Penable are registered, so they are computed for the state being
  // entered rather than decoded from the current one.
  always_comb begin
    state_d     = state_q;
    psel_d      = 1'b0;
    penable_d   = 1'b0;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          pwrite_d = req_write;
          paddr_d  = req_addr;
          pwdata_d = req_wdata;
          psel_d   = 1'b1;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (Pready) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : PRdata;
          state_d     = IDLE;
        end else if (wait_expired) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = IDLE;
        end else begin
          psel_d    = 1'b1;
          penable_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge Presetn) begin
    if (!Presetn) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign Psel      = psel_q;
  assign Penable   = penable_q;
  assign Pwrite    = pwrite_q;
  assign Paddress  = paddr_q;
  assign Pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: a simple memory-backed APB slave, directed scenarios
// followed by randomized transfers checked against a memory reference model.
module tb_apb_master;

  localparam int K       = 8;
  localparam int A       = 4;
  localparam int TIMEOUT = 16;

  logic         PCLK;
  logic         Presetn;
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic [A-1:0] req_addr;
  logic [K-1:0] req_wdata;
  logic         rsp_valid;
  logic [K-1:0] rsp_rdata;
  logic         rsp_err;
  logic         Psel;
  logic         Penable;
  logic         Pwrite;
  logic [A-1:0] Paddress;
  logic [K-1:0] Pwdata;
  logic         Pready;
  logic [K-1:0] PRdata;

  int n_chk  = 0;
  int n_fail = 0;

  logic [K-1:0] slv_mem   [16];
  logic [K-1:0] model_mem [16];

  apb_master #(.K(K), .A(A), .TIMEOUT(TIMEOUT)) dut (
    .PCLK     (PCLK),
    .Presetn  (Presetn),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .Psel     (Psel),
    .Penable  (Penable),
    .Pwrite   (Pwrite),
    .Paddress (Paddress),
    .Pwdata   (Pwdata),
    .Pready   (Pready),
    .PRdata   (PRdata)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Slave: completes a write on the edge closing a ready ACCESS cycle.
  always @(posedge PCLK) begin
    if (Psel && Penable && Pready && Pwrite) slv_mem[Paddress] <= Pwdata;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts at the negedge of an IDLE cycle; ends at the negedge of the
  // response cycle (or one cycle later when valid is not kept high).
  // nwait = Pready-low cycles the slave inserts; >= TIMEOUT means a hung slave.
  task automatic xfer(input bit w, input logic [A-1:0] a, input logic [K-1:0] d,
                      input int nwait, input bit keep_valid);
    bit           exp_err;
    int           acc;
    logic [K-1:0] exp_rd;
    exp_err = (nwait >= TIMEOUT);
    acc     = exp_err ? TIMEOUT : nwait + 1;
    exp_rd  = (w || exp_err) ? '0 : model_mem[a];
    chk("idle_ready", req_ready, 1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    Pready = 1'($urandom); PRdata = K'($urandom);
    @(negedge PCLK);
    chk("setup_psel_pen", {Psel, Penable}, 2'b10);
    chk("setup_ready", req_ready, 0);
    chk("setup_addr", Paddress, a);
    if (!keep_valid) begin
      req_valid = 1'b0; req_write = 1'($urandom);
      req_addr = A'($urandom); req_wdata = K'($urandom);
    end
    Pready = 1'b1;             // must be ignored in SETUP
    PRdata = K'($urandom);
    @(negedge PCLK);
    for (int k = 0; k < acc; k++) begin
      chk("acc_psel_pen", {Psel, Penable}, 2'b11);
      chk("acc_addr", Paddress, a);
      chk("acc_wdata", Pwdata, d);
      chk("acc_write", Pwrite, w);
      chk("acc_ready", req_ready, 0);
      chk("acc_rsp", rsp_valid, 0);
      if (k == acc - 1 && !exp_err) begin
        Pready = 1'b1; PRdata = slv_mem[Paddress];
      end else begin
        Pready = 1'b0; PRdata = K'($urandom);
      end
      @(negedge PCLK);
    end
    Pready = 1'($urandom); PRdata = K'($urandom);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_err", rsp_err, exp_err);
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("rsp_psel_pen", {Psel, Penable}, 2'b00);
    chk("rsp_ready", req_ready, 1);
    if (w && !exp_err) model_mem[a] = d;
    if (!keep_valid) begin
      req_valid = 1'b0;
      @(negedge PCLK);
      chk("post_rsp_low", rsp_valid, 0);
      chk("post_psel", Psel, 0);
      chk("hold_addr", Paddress, a);
      chk("hold_wdata", Pwdata, d);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      slv_mem[i] = '0; model_mem[i] = '0;
    end
    Presetn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; Pready = 1'b0; PRdata = '0;
    repeat (2) @(negedge PCLK);
    chk("rst_psel_pen", {Psel, Penable}, 2'b00);
    chk("rst_rsp", {rsp_valid, rsp_err}, 2'b00);
    chk("rst_addr", Paddress, 0);
    chk("rst_wdata", Pwdata, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_pwrite", Pwrite, 0);
    chk("rst_ready", req_ready, 1);
    Presetn = 1'b1;
    @(negedge PCLK);

    // Zero-wait write then read-back.
    xfer(1'b1, 4'h5, 8'hA5, 0, 1'b0);
    chk("slave_mem5", slv_mem[5], 8'hA5);
    xfer(1'b0, 4'h5, 8'h00, 0, 1'b0);
    // Wait states, then the timeout boundary on either side.
    xfer(1'b1, 4'h9, 8'h3C, 3, 1'b0);
    xfer(1'b0, 4'h9, 8'h00, 3, 1'b0);
    xfer(1'b1, 4'h2, 8'h77, TIMEOUT, 1'b0);
    chk("timeout_no_write", slv_mem[2], 8'h00);
    xfer(1'b0, 4'h9, 8'h00, TIMEOUT - 1, 1'b0);
    xfer(1'b0, 4'h5, 8'h00, TIMEOUT, 1'b0);
    xfer(1'b1, 4'h2, 8'h77, 0, 1'b0);

    // Back-to-back writes with req_valid held high.
    for (int i = 0; i < 4; i++) xfer(1'b1, A'(i), K'(8'h10 + i), 0, i != 3);
    for (int i = 0; i < 4; i++) xfer(1'b0, A'(i), 8'h00, 0, i != 3);

    // Reset in the middle of a waited ACCESS.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 4'hC; req_wdata = 8'hEE;
    @(negedge PCLK);
    req_valid = 1'b0;
    @(negedge PCLK);
    Pready = 1'b0;
    @(negedge PCLK);
    chk("pre_rst_access", {Psel, Penable}, 2'b11);
    Presetn = 1'b0;
    #1;
    chk("midrst_psel_pen", {Psel, Penable}, 2'b00);
    chk("midrst_rsp", rsp_valid, 0);
    chk("midrst_addr", Paddress, 0);
    chk("midrst_ready", req_ready, 1);
    @(negedge PCLK);
    Presetn = 1'b1;
    repeat (3) begin
      @(negedge PCLK);
      chk("postrst_rsp", rsp_valid, 0);
      chk("postrst_psel", Psel, 0);
      chk("postrst_ready", req_ready, 1);
    end
    chk("midrst_no_write", slv_mem[12], 8'h00);
    xfer(1'b0, 4'h5, 8'h00, 1, 1'b0);

    // Randomized traffic against the memory model.
    for (int i = 0; i < 30; i++) begin
      int nw;
      nw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(TIMEOUT - 2, TIMEOUT + 1))
                                       : int'($urandom_range(0, 3));
      xfer(1'($urandom), A'($urandom), K'($urandom), nw, 1'($urandom_range(0, 1)));
    end
    req_valid = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    chk("final_idle", {Psel, rsp_valid, req_ready}, 3'b001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
